// File: rtl/exec_unit_if.sv
// Request and register-file write-back bus of the execution unit.
// The master issues operations; the slave (exec_unit) returns writes and flags.
interface exec_unit_if;
   logic       i_start;
   logic [2:0] i_op;
   logic [2:0] i_dst;
   logic [7:0] i_a;
   logic [7:0] i_b;
   logic       o_busy;
   logic       o_done;
   logic       RF_w_en;
   logic [2:0] w_addr;
   logic [7:0] w_data;
   logic [3:0] o_flags;

   modport master (
      output i_start, i_op, i_dst, i_a, i_b,
      input  o_busy, o_done, RF_w_en, w_addr, w_data, o_flags
   );

   modport slave (
      input  i_start, i_op, i_dst, i_a, i_b,
      output o_busy, o_done, RF_w_en, w_addr, w_data, o_flags
   );
endinterface

// File: rtl/exec_unit.sv
// 8-bit execution unit: single-cycle ALU ops and an optional 8-step shift-add
// multiply, each finishing with one register-file write-back cycle.
module exec_unit #(
   parameter bit MUL_EN = 1'b1
) (
   input logic         clk,
   input logic         rst,
   exec_unit_if.slave  bus
);

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpAnd = 3'b010;
   localparam logic [2:0] OpOr  = 3'b011;
   localparam logic [2:0] OpXor = 3'b100;
   localparam logic [2:0] OpShl = 3'b101;
   localparam logic [2:0] OpShr = 3'b110;
   localparam logic [2:0] OpMul = 3'b111;

   typedef enum logic [1:0] {StIdle, StMul, StWb} state_e;

   state_e      state_q, state_d;
   logic [2:0]  dst_q;
   logic [7:0]  a_q, b_q;
   logic [15:0] acc_q;
   logic [2:0]  cnt_q;
   logic [7:0]  res_q;
   logic [3:0]  flags_q;

   logic        accept;
   logic        mul_path;
   logic [8:0]  sum9, diff9;
   logic [7:0]  alu_res;
   logic        alu_c, alu_v;
   logic [15:0] mul_addend, acc_nxt;
   logic        mul_last;

   assign accept   = (state_q == StIdle) && bus.i_start;
   assign mul_path = MUL_EN && (bus.i_op == OpMul);

   assign sum9  = {1'b0, bus.i_a} + {1'b0, bus.i_b};
   assign diff9 = {1'b0, bus.i_a} - {1'b0, bus.i_b};

   // Single-cycle ops are evaluated on the operands present at the accept
   // edge, i.e. exactly the values being latched.
   always_comb begin
      alu_res = 8'h00;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (bus.i_op)
         OpAdd: begin
            alu_res = sum9[7:0];
            alu_c   = sum9[8];
            alu_v   = (bus.i_a[7] == bus.i_b[7]) && (alu_res[7] != bus.i_a[7]);
         end
         OpSub: begin
            alu_res = diff9[7:0];
            alu_c   = diff9[8];
            alu_v   = (bus.i_a[7] != bus.i_b[7]) && (alu_res[7] != bus.i_a[7]);
         end
         OpAnd: alu_res = bus.i_a & bus.i_b;
         OpOr:  alu_res = bus.i_a | bus.i_b;
         OpXor: alu_res = bus.i_a ^ bus.i_b;
         OpShl: begin
            alu_res = {bus.i_a[6:0], 1'b0};
            alu_c   = bus.i_a[7];
         end
         OpShr: begin
            alu_res = {1'b0, bus.i_a[7:1]};
            alu_c   = bus.i_a[0];
         end
         // Multiply disabled: fixed zero result.
         default: alu_res = 8'h00;
      endcase
   end

   assign mul_addend = b_q[cnt_q] ? ({8'h00, a_q} << cnt_q) : 16'h0000;
   assign acc_nxt    = acc_q + mul_addend;
   assign mul_last   = (cnt_q == 3'd7);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (bus.i_start) begin
               state_d = mul_path ? StMul : StWb;
            end
         end
         StMul: begin
            if (mul_last) begin
               state_d = StWb;
            end
         end
         StWb:    state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.o_busy  = (state_q != StIdle);
      bus.o_done  = (state_q == StWb);
      bus.RF_w_en = (state_q == StWb);
      bus.w_addr  = (state_q == StWb) ? dst_q : 3'd0;
      bus.w_data  = (state_q == StWb) ? res_q : 8'h00;
      bus.o_flags = flags_q;
   end

   // Flags and result load only on the edge that enters write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         dst_q   <= 3'd0;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         acc_q   <= 16'h0000;
         cnt_q   <= 3'd0;
         res_q   <= 8'h00;
         flags_q <= 4'h0;
      end else if (accept) begin
         dst_q <= bus.i_dst;
         a_q   <= bus.i_a;
         b_q   <= bus.i_b;
         acc_q <= 16'h0000;
         cnt_q <= 3'd0;
         if (!mul_path) begin
            res_q   <= alu_res;
            flags_q <= {alu_res == 8'h00, alu_res[7], alu_c, alu_v};
         end
      end else if (state_q == StMul) begin
         acc_q <= acc_nxt;
         cnt_q <= cnt_q + 3'd1;
         if (mul_last) begin
            res_q   <= acc_nxt[7:0];
            flags_q <= {acc_nxt[7:0] == 8'h00, acc_nxt[7], acc_nxt[15:8] != 8'h00, 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_exec_unit.sv
// Table-driven bench for exec_unit with a write-back scoreboard and
// hand-written sequences for ignored-start and mid-multiply reset.
module tb_exec_unit;

   typedef struct {
      logic [2:0] op;
      logic [2:0] dst;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] data;
      logic [3:0] flags;
   } vec_t;

   typedef struct {
      logic [2:0] dst;
      logic [7:0] data;
      logic [3:0] flags;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   done_cnt = 0;
   exp_t sb[$];
   vec_t vecs[16];

   exec_unit_if bus ();

   exec_unit #(.MUL_EN(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model written with integer arithmetic.
   function automatic void model(input logic [2:0] op, input logic [7:0] a,
                                 input logic [7:0] b, output logic [7:0] r,
                                 output logic [3:0] f);
      int ua, ub, sa, sb_, full, sres;
      logic c, v;
      ua = int'(a); ub = int'(b);
      sa = (ua > 127) ? ua - 256 : ua;
      sb_ = (ub > 127) ? ub - 256 : ub;
      c = 1'b0; v = 1'b0; full = 0;
      case (op)
         3'd0: begin full = ua + ub; sres = sa + sb_; c = (full > 255);
                     v = (sres > 127) || (sres < -128); end
         3'd1: begin full = ua - ub + 256; sres = sa - sb_; c = (ua < ub);
                     v = (sres > 127) || (sres < -128); end
         3'd2: full = ua & ub;
         3'd3: full = ua | ub;
         3'd4: full = ua ^ ub;
         3'd5: begin full = ua * 2; c = (ua >= 128); end
         3'd6: begin full = ua / 2; c = (ua % 2) == 1; end
         default: begin full = ua * ub; c = (full > 255); end
      endcase
      r = 8'(full % 256);
      f = {r == 8'h00, r[7], c, v};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (bus.o_busy !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (bus.o_busy !== 1'b0) begin
         n_vec++;
         n_bad++;
         $display("FAIL wait_idle: o_busy=%b still set after 50 cycles, required 0", bus.o_busy);
      end
   endtask

   // Drive one request from a negedge, record the expectation, then scramble
   // the operands after the accept edge.
   task automatic issue(input logic [2:0] op, input logic [2:0] dst, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ed, input logic [3:0] ef);
      exp_t e;
      wait_idle();
      bus.i_start = 1'b1;
      bus.i_op    = op;
      bus.i_dst   = dst;
      bus.i_a     = a;
      bus.i_b     = b;
      e.dst   = dst;
      e.data  = ed;
      e.flags = ef;
      e.cyc   = cyc + 1 + ((op == 3'd7) ? 8 : 0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      bus.i_op    = 3'($urandom_range(0, 7));
      bus.i_dst   = 3'($urandom_range(0, 7));
      bus.i_a     = 8'($urandom_range(0, 255));
      bus.i_b     = 8'($urandom_range(0, 255));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.o_done !== bus.RF_w_en) begin
            n_bad++;
            $display("FAIL done_vs_wen: o_done=%b RF_w_en=%b, required equal",
                     bus.o_done, bus.RF_w_en);
         end
         if (bus.RF_w_en === 1'b1) begin
            done_cnt++;
            n_vec++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_write: addr=%0d data=%h at cycle %0d, required no write",
                        bus.w_addr, bus.w_data, cyc);
            end else begin
               e = sb.pop_front();
               if (bus.w_addr !== e.dst || bus.w_data !== e.data ||
                   bus.o_flags !== e.flags || cyc != e.cyc) begin
                  n_bad++;
                  $display("FAIL writeback: got addr=%0d data=%h flags=%b cyc=%0d, required addr=%0d data=%h flags=%b cyc=%0d",
                           bus.w_addr, bus.w_data, bus.o_flags, cyc,
                           e.dst, e.data, e.flags, e.cyc);
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] r;
      logic [3:0] f;
      logic [2:0] op;
      logic [7:0] a, b;
      int         d0, n;

      vecs[0]  = '{3'd0, 3'd3, 8'h7F, 8'h01, 8'h80, 4'b0101};
      vecs[1]  = '{3'd1, 3'd1, 8'h05, 8'h05, 8'h00, 4'b1000};
      vecs[2]  = '{3'd1, 3'd2, 8'h00, 8'h01, 8'hFF, 4'b0110};
      vecs[3]  = '{3'd7, 3'd5, 8'h10, 8'h10, 8'h00, 4'b1010};
      vecs[4]  = '{3'd7, 3'd6, 8'h0C, 8'h0B, 8'h84, 4'b0100};
      vecs[5]  = '{3'd2, 3'd0, 8'hF0, 8'h3C, 8'h30, 4'b0000};
      vecs[6]  = '{3'd3, 3'd1, 8'hF0, 8'h0F, 8'hFF, 4'b0100};
      vecs[7]  = '{3'd4, 3'd2, 8'hAA, 8'hAA, 8'h00, 4'b1000};
      vecs[8]  = '{3'd0, 3'd3, 8'hFF, 8'h01, 8'h00, 4'b1010};
      vecs[9]  = '{3'd0, 3'd4, 8'h80, 8'h80, 8'h00, 4'b1011};
      vecs[10] = '{3'd1, 3'd5, 8'h80, 8'h01, 8'h7F, 4'b0001};
      vecs[11] = '{3'd7, 3'd7, 8'hFF, 8'hFF, 8'h01, 4'b0010};
      vecs[12] = '{3'd5, 3'd1, 8'h40, 8'h00, 8'h80, 4'b0100};
      vecs[13] = '{3'd7, 3'd0, 8'h00, 8'h37, 8'h00, 4'b1000};
      vecs[14] = '{3'd5, 3'd7, 8'h81, 8'h5A, 8'h02, 4'b0010};
      vecs[15] = '{3'd6, 3'd4, 8'h01, 8'hC3, 8'h00, 4'b1010};

      bus.i_start = 1'b0;
      bus.i_op    = 3'd0;
      bus.i_dst   = 3'd0;
      bus.i_a     = 8'h00;
      bus.i_b     = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk("reset_busy", 16'(bus.o_busy), 16'h0);
      chk("reset_done", 16'(bus.o_done), 16'h0);
      chk("reset_wen", 16'(bus.RF_w_en), 16'h0);
      chk("reset_waddr", 16'(bus.w_addr), 16'h0);
      chk("reset_wdata", 16'(bus.w_data), 16'h0);
      chk("reset_flags", 16'(bus.o_flags), 16'h0);

      for (int i = 0; i < 16; i++) begin
         issue(vecs[i].op, vecs[i].dst, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].flags);
      end

      // Flags hold while idle after the last write.
      wait_idle();
      repeat (4) @(negedge clk);
      chk("idle_hold_flags", 16'(bus.o_flags), 16'(4'b1010));
      chk("idle_wen", 16'(bus.RF_w_en), 16'h0);

      // Start pulsed during multiply iteration 3 is ignored.
      d0 = done_cnt;
      issue(3'd7, 3'd2, 8'h03, 8'h05, 8'h0F, 4'b0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_op    = 3'd0;
      bus.i_dst   = 3'd6;
      bus.i_a     = 8'h11;
      bus.i_b     = 8'h22;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      chk("ignored_start_done_count", 16'(done_cnt - d0), 16'd1);

      // Reset during multiply iteration 4 aborts with no write.
      wait_idle();
      bus.i_start = 1'b1;
      bus.i_op    = 3'd7;
      bus.i_dst   = 3'd3;
      bus.i_a     = 8'h12;
      bus.i_b     = 8'h34;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("mul_busy_before_abort", 16'(bus.o_busy), 16'h1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", 16'(bus.o_busy), 16'h0);
      chk("abort_flags", 16'(bus.o_flags), 16'h0);
      chk("abort_wen", 16'(bus.RF_w_en), 16'h0);
      d0 = done_cnt;
      repeat (12) @(negedge clk);
      chk("abort_no_write", 16'(done_cnt - d0), 16'd0);

      // Random operations against the reference model.
      for (int i = 0; i < 20; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = 8'($urandom_range(0, 255));
         b  = 8'($urandom_range(0, 255));
         model(op, a, b, r, f);
         issue(op, 3'($urandom_range(0, 7)), a, b, r, f);
      end

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", 16'(sb.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter: MUL_EN, default 1, 1 enables the multi-cycle multiply for opcode 111.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 i_start  input  1  request strobe; sampled only when o_busy=0.
REQ-005 i_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-006 i_dst  input  3  destination register address.
REQ-007 i_a  input  8  operand A, driven from register-file read port 0.
REQ-008 i_b  input  8  operand B, driven from register-file read port 1.
REQ-009 o_busy  output  1  high while an accepted operation is not yet written back.
REQ-010 o_done  output  1  one-cycle pulse, coincident with RF_w_en.
REQ-011 RF_w_en  output  1  register-file write enable.
REQ-012 w_addr  output  3  register-file write address.
REQ-013 w_data  output  8  register-file write data.
REQ-014 o_flags  output  4  {Z,N,C,V}, registered.

Function
REQ-015 FSM states SHALL be IDLE, MUL and WB; o_busy = (state != IDLE).
REQ-016 IDLE with i_start=1 SHALL latch i_op, i_dst, i_a and i_b at the edge ("accept edge").
REQ-017 For non-MUL ops, the accept edge SHALL move the FSM to WB with the result computed from the latched operands.
REQ-018 In WB, RF_w_en=1, o_done=1, w_addr=latched dst and w_data=result SHALL hold for exactly one cycle; the next edge returns the FSM to IDLE.
REQ-019 Non-MUL latency: the write is visible in the cycle after the accept edge.
REQ-020 ADD: result = a+b mod 256; C = carry out of bit 7; V = signed overflow.
REQ-021 SUB: result = a-b mod 256; C = borrow (1 when a<b unsigned); V = signed overflow.
REQ-022 AND, OR, XOR: bitwise result; C=0; V=0.
REQ-023 SHL: result = {a[6:0],0}, C=a[7]. SHR: result = {0,a[7:1]}, C=a[0]. V=0 for both; b is ignored.
REQ-024 For every op, Z=(result==0) and N=result[7].
REQ-025 MUL with MUL_EN=1: the accept edge SHALL enter MUL, loading an accumulator (16 bit) = 0 and an iteration counter = 0.
REQ-026 Each MUL-state edge SHALL perform one shift-add step, using the LSB-first bit of b, and increment the counter.
REQ-027 After 8 iterations the FSM SHALL enter WB.
REQ-028 MUL results: w_data = product[7:0]; C = (product[15:8] != 0); V=0.
REQ-029 MUL timing: 8 MUL-state cycles, with WB in the 9th cycle after the accept edge.
REQ-030 MUL with MUL_EN=0: single-cycle path to WB with result 0x00, Z=1 and N=C=V=0.
REQ-031 o_flags SHALL update only at the edge entering WB and SHALL hold otherwise.
REQ-032 i_start while o_busy=1 (in MUL or WB) SHALL be ignored, not queued.
REQ-033 Operand changes after the accept edge SHALL NOT affect the result.
REQ-034 i_dst=0 SHALL still assert RF_w_en and update flags; the register file discards the write.
REQ-035 Back-to-back ops: accept, WB, IDLE; the earliest next accept is the edge leaving IDLE, so throughput is at most 1 op per 2 cycles.

Reset
REQ-036 rst=1 at a rising edge SHALL force state IDLE and o_busy=0, o_done=0, RF_w_en=0, w_addr=0, w_data=0, o_flags=0, and clear the accumulator, counter and latches.
REQ-037 rst SHALL take priority over i_start and over any in-progress MUL or WB.
REQ-038 An aborted operation SHALL produce no write.

Verification
REQ-039 ADD a=0x7F b=0x01 dst=3 -> next cycle RF_w_en=1, w_addr=3, w_data=0x80, flags Z0 N1 C0 V1.
REQ-040 SUB a=0x05 b=0x05 -> w_data=0x00, Z1 N0 C0 V0; then SUB a=0x00 b=0x01 -> w_data=0xFF, N1 C1.
REQ-041 MUL a=0x10 b=0x10 dst=5 -> o_busy high for 9 cycles, o_done in the 9th cycle after accept, w_data=0x00, Z1 C1; MUL a=0x0C b=0x0B -> w_data=0x84, C0 N1.
REQ-042 i_start pulsed with ADD during MUL iteration 3 -> ignored, exactly one write (the MUL result) and no extra o_done.
REQ-043 rst asserted during MUL iteration 4 -> next cycle o_busy=0, o_flags=0, and RF_w_en never asserts for that op.
REQ-044 SHL a=0x81 then SHR a=0x01 -> 0x02 with C1, then 0x00 with Z1 C1; flags hold while idle.
